elevator_scheduler: RTL and testbench

//  Request scheduler and motion sequencer for the single elevator car. Latches hall-up,

---
 rtl/elevator_scheduler_pkg.sv | 25 ++
 rtl/elevator_scheduler_timer.sv | 38 +++
 rtl/elevator_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_scheduler_pkg.sv
// Shared types and defaults for the elevator scheduler.
package elevator_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR      = 2'd3
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int unsigned DEF_NUM_FLOORS  = 8;
    localparam int unsigned DEF_FLOOR_W     = 3;
    localparam int unsigned DEF_FLOOR_TICKS = 50_000_000;
    localparam int unsigned DEF_DOOR_TICKS  = 100_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/elevator_scheduler_timer.sv
// Loadable down-counter shared by the travel and door phases; done while the count is zero.
module elevator_scheduler_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         done_q;

    // Next count: load wins, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter and registered zero flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            done_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= (cnt_d == '0);
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/elevator_scheduler.sv
// LOOK-order request scheduler and motion sequencer for a single elevator car.
module elevator_scheduler
    import elevator_scheduler_pkg::*;
#(
    parameter int unsigned NUM_FLOORS  = DEF_NUM_FLOORS,
    parameter int unsigned FLOOR_W     = DEF_FLOOR_W,
    parameter int unsigned FLOOR_TICKS = DEF_FLOOR_TICKS,
    parameter int unsigned DOOR_TICKS  = DEF_DOOR_TICKS
) (
    input  logic                  clk,
    input  logic                  resetBtn,
    input  logic [FLOOR_W-1:0]    req_floor,
    input  logic                  req_up,
    input  logic                  req_down,
    input  logic                  req_cab,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int unsigned TIMER_W = $clog2(max_u(FLOOR_TICKS, DOOR_TICKS)) + 1;
    localparam logic [NUM_FLOORS-1:0] BOT_BIT = NUM_FLOORS'(1);
    localparam logic [NUM_FLOORS-1:0] TOP_BIT = BOT_BIT << (NUM_FLOORS - 1);

    function automatic logic [NUM_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) if (32'(f) == i) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] above(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) if (i > 32'(f)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) if (i < 32'(f)) m[i] = 1'b1;
        return m;
    endfunction

    state_e                state_q, state_d;
    dir_e                  dir_q, dir_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d, nf;
    logic [NUM_FLOORS-1:0] up_q, up_d, dn_q, dn_d, cab_q, cab_d, pending_q;
    logic [NUM_FLOORS-1:0] set_up, set_dn, set_cab, clr_up, clr_dn, clr_cab;
    logic [NUM_FLOORS-1:0] req_oh, all_q, cur_oh, nf_oh;
    logic                  mu_q, md_q, door_q;
    logic                  above_cur, below_cur, at_cur, req_at_cur, ahead, behind;
    logic                  further_nf, hall_dir_nf, hall_opp_nf, cab_nf;
    logic                  tmr_load, tmr_done;
    logic [TIMER_W-1:0]    tmr_val;

    // Request decode: out-of-range floors, up at top and down at bottom never set a bit.
    assign req_oh  = onehot(req_floor);
    assign set_up  = req_up   ? (req_oh & ~TOP_BIT) : '0;
    assign set_dn  = req_down ? (req_oh & ~BOT_BIT) : '0;
    assign set_cab = req_cab  ? req_oh : '0;

    // Request masks relative to the current floor and the floor being approached.
    assign all_q       = up_q | dn_q | cab_q;
    assign cur_oh      = onehot(floor_q);
    assign nf          = (state_q == ST_MOVE_DOWN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);
    assign nf_oh       = onehot(nf);
    assign above_cur   = |(all_q & above(floor_q));
    assign below_cur   = |(all_q & below(floor_q));
    assign at_cur      = |(all_q & cur_oh);
    assign req_at_cur  = |((set_up | set_dn | set_cab) & cur_oh);
    assign ahead       = (dir_q == DIR_UP) ? above_cur : below_cur;
    assign behind      = (dir_q == DIR_UP) ? below_cur : above_cur;
    assign further_nf  = (state_q == ST_MOVE_DOWN) ? |(all_q & below(nf)) : |(all_q & above(nf));
    assign hall_dir_nf = (state_q == ST_MOVE_DOWN) ? |(dn_q & nf_oh) : |(up_q & nf_oh);
    assign hall_opp_nf = (state_q == ST_MOVE_DOWN) ? |(up_q & nf_oh) : |(dn_q & nf_oh);
    assign cab_nf      = |(cab_q & nf_oh);

    // Next-state, direction, floor, timer control and request clears.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        floor_d  = floor_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        clr_up   = '0;
        clr_dn   = '0;
        clr_cab  = '0;
        case (state_q)
            ST_IDLE: begin
                if (at_cur) begin
                    state_d  = ST_DOOR;
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(DOOR_TICKS - 1);
                    clr_up   = cur_oh;
                    clr_dn   = cur_oh;
                    clr_cab  = cur_oh;
                end else if (above_cur || below_cur) begin
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(FLOOR_TICKS - 1);
                    if ((dir_q == DIR_UP && above_cur) || (dir_q == DIR_DOWN && !below_cur)) begin
                        state_d = ST_MOVE_UP;
                        dir_d   = DIR_UP;
                    end else begin
                        state_d = ST_MOVE_DOWN;
                        dir_d   = DIR_DOWN;
                    end
                end
            end
            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (tmr_done) begin
                    floor_d = nf;
                    if (cab_nf || hall_dir_nf || (hall_opp_nf && !further_nf)) begin
                        state_d  = ST_DOOR;
                        tmr_load = 1'b1;
                        tmr_val  = TIMER_W'(DOOR_TICKS - 1);
                        clr_cab  = nf_oh;
                        if (state_q == ST_MOVE_UP || !further_nf) clr_up = nf_oh;
                        if (state_q == ST_MOVE_DOWN || !further_nf) clr_dn = nf_oh;
                    end else if (further_nf) begin
                        tmr_load = 1'b1;
                        tmr_val  = TIMER_W'(FLOOR_TICKS - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DOOR: begin
                // Calls for this floor while the door is open are absorbed and hold the door.
                clr_up  = set_up & cur_oh;
                clr_dn  = set_dn & cur_oh;
                clr_cab = set_cab & cur_oh;
                if (req_at_cur) begin
                    tmr_load = 1'b1;
                    tmr_val  = TIMER_W'(DOOR_TICKS - 1);
                end else if (tmr_done) begin
                    if (ahead) begin
                        state_d  = (dir_q == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
                        tmr_load = 1'b1;
                        tmr_val  = TIMER_W'(FLOOR_TICKS - 1);
                    end else if (behind) begin
                        state_d  = (dir_q == DIR_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
                        dir_d    = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                        tmr_load = 1'b1;
                        tmr_val  = TIMER_W'(FLOOR_TICKS - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latches: a clear in the same cycle as a set wins.
    assign up_d  = (up_q  | set_up)  & ~clr_up;
    assign dn_d  = (dn_q  | set_dn)  & ~clr_dn;
    assign cab_d = (cab_q | set_cab) & ~clr_cab;

    // State, request and registered output update.
    always_ff @(posedge clk) begin
        if (resetBtn) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_UP;
            floor_q   <= '0;
            up_q      <= '0;
            dn_q      <= '0;
            cab_q     <= '0;
            pending_q <= '0;
            mu_q      <= 1'b0;
            md_q      <= 1'b0;
            door_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            floor_q   <= floor_d;
            up_q      <= up_d;
            dn_q      <= dn_d;
            cab_q     <= cab_d;
            pending_q <= up_d | dn_d | cab_d;
            mu_q      <= (state_d == ST_MOVE_UP);
            md_q      <= (state_d == ST_MOVE_DOWN);
            door_q    <= (state_d == ST_DOOR);
        end
    end

    elevator_scheduler_timer #(.W(TIMER_W)) u_timer (
        .clk_i      (clk),
        .rst_i      (resetBtn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    assign current_floor = floor_q;
    assign moving_up     = mu_q;
    assign moving_down   = md_q;
    assign door_open     = door_q;
    assign pending       = pending_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler: request-latch vector table plus scheduled scenarios.
module tb_elevator_scheduler;

    localparam int unsigned NF = 8;
    localparam int unsigned FW = 4;

    logic          clk = 1'b0;
    logic          resetBtn = 1'b1;
    logic [FW-1:0] req_floor = '0;
    logic          req_up = 1'b0;
    logic          req_down = 1'b0;
    logic          req_cab = 1'b0;
    logic [FW-1:0] current_floor;
    logic          moving_up, moving_down, door_open;
    logic [NF-1:0] pending;

    elevator_scheduler #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (FW),
        .FLOOR_TICKS (4),
        .DOOR_TICKS  (3)
    ) dut (
        .clk           (clk),
        .resetBtn      (resetBtn),
        .req_floor     (req_floor),
        .req_up        (req_up),
        .req_down      (req_down),
        .req_cab       (req_cab),
        .current_floor (current_floor),
        .moving_up     (moving_up),
        .moving_down   (moving_down),
        .door_open     (door_open),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        string       name;
        int unsigned fl;
        bit          mu;
        bit          md;
        bit          dr;
        logic [7:0]  pend;
    } exp_t;

    typedef struct {
        logic [3:0] fl;
        bit         u;
        bit         d;
        bit         c;
        logic [7:0] pend1;
        bit         mu3;
        bit         dr3;
        logic [7:0] pend3;
    } vec_t;

    exp_t exp_q[$];
    exp_t cur_e;
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic expect_at(input int c, input string nm, input int unsigned fl,
                             input bit mu, input bit md, input bit dr, input logic [7:0] pd);
        exp_t e;
        e.c = c; e.name = nm; e.fl = fl; e.mu = mu; e.md = md; e.dr = dr; e.pend = pd;
        exp_q.push_back(e);
    endtask

    // Scoreboard: compare every expectation due this cycle, on the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0].c <= cyc) begin
            cur_e = exp_q.pop_front();
            n_checks++;
            if (cur_e.c != cyc) begin
                n_fail++;
                $display("FAIL %s: check due at cycle %0d reached at %0d", cur_e.name, cur_e.c, cyc);
            end else if (current_floor !== FW'(cur_e.fl) || moving_up !== cur_e.mu ||
                         moving_down !== cur_e.md || door_open !== cur_e.dr ||
                         pending !== cur_e.pend) begin
                n_fail++;
                $display("FAIL %s @%0d: got floor=%0d up=%b dn=%b door=%b pend=%h, want floor=%0d up=%b dn=%b door=%b pend=%h",
                         cur_e.name, cyc, current_floor, moving_up, moving_down, door_open, pending,
                         cur_e.fl, cur_e.mu, cur_e.md, cur_e.dr, cur_e.pend);
            end
        end
    end

    // Drive inputs during cycle 'target' and hold them for n cycles.
    task automatic drive(input int target, input logic rst, input logic [FW-1:0] f,
                         input logic u, input logic d, input logic c, input int n);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
        resetBtn = rst; req_floor = f; req_up = u; req_down = d; req_cab = c;
        repeat (n) begin
            @(posedge clk); #1;
        end
        resetBtn = 1'b0; req_floor = '0; req_up = 1'b0; req_down = 1'b0; req_cab = 1'b0;
    endtask

    task automatic run_reset();
        drive(cyc, 1'b1, '0, 1'b0, 1'b0, 1'b0, 2);
    endtask

    task automatic wait_drain(input string nm);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(posedge clk); #1;
            g++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d checks outstanding, required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        vecs[0] = '{4'd9,  1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{4'd7,  1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{4'd0,  1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{4'd8,  1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{4'd3,  1'b0, 1'b0, 1'b1, 8'h08, 1'b1, 1'b0, 8'h08};
        vecs[5] = '{4'd7,  1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 8'h80};
        vecs[6] = '{4'd0,  1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 8'h00};
        vecs[7] = '{4'd4,  1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8'h10};
        vecs[8] = '{4'd7,  1'b1, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 8'h80};
        vecs[9] = '{4'd15, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00};

        @(posedge clk); #1;
        expect_at(cyc + 1, "reset_init", 0, 0, 0, 0, 8'h00);
        run_reset();
        wait_drain("reset_init");

        // Request latch and ignore rules from an idle car at floor 0.
        for (int i = 0; i < 10; i++) begin
            run_reset();
            t = cyc;
            expect_at(t + 1, $sformatf("vec%0d_latch", i), 0, 0, 0, 0, vecs[i].pend1);
            expect_at(t + 3, $sformatf("vec%0d_t3", i), 0, vecs[i].mu3, 0, vecs[i].dr3, vecs[i].pend3);
            drive(t, 1'b0, vecs[i].fl, vecs[i].u, vecs[i].d, vecs[i].c, 1);
            wait_drain("vec");
        end

        // Reset held two cycles while moving up; the request pulsed with reset is lost.
        run_reset();
        t = cyc;
        expect_at(t + 6,  "s1_moving",   1, 1, 0, 0, 8'h80);
        expect_at(t + 8,  "s1_rst",      0, 0, 0, 0, 8'h00);
        expect_at(t + 9,  "s1_rst_hold", 0, 0, 0, 0, 8'h00);
        expect_at(t + 12, "s1_after",    0, 0, 0, 0, 8'h00);
        drive(t, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 1);
        drive(t + 7, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 2);
        wait_drain("s1");

        // Cab call 0 -> 3: travel timing, door dwell, clear on arrival.
        run_reset();
        t = cyc;
        expect_at(t + 1,  "s2_latch",  0, 0, 0, 0, 8'h08);
        expect_at(t + 2,  "s2_start",  0, 1, 0, 0, 8'h08);
        expect_at(t + 5,  "s2_f0_end", 0, 1, 0, 0, 8'h08);
        expect_at(t + 6,  "s2_f1",     1, 1, 0, 0, 8'h08);
        expect_at(t + 10, "s2_f2",     2, 1, 0, 0, 8'h08);
        expect_at(t + 13, "s2_f2_end", 2, 1, 0, 0, 8'h08);
        expect_at(t + 14, "s2_door",   3, 0, 0, 1, 8'h00);
        expect_at(t + 16, "s2_door3",  3, 0, 0, 1, 8'h00);
        expect_at(t + 17, "s2_idle",   3, 0, 0, 0, 8'h00);
        drive(t, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 1);
        wait_drain("s2");

        // Up hall call at 2 ahead of a car heading for 5: intermediate stop.
        run_reset();
        t = cyc;
        expect_at(t + 10, "s3a_stop2",  2, 0, 0, 1, 8'h20);
        expect_at(t + 12, "s3a_door3",  2, 0, 0, 1, 8'h20);
        expect_at(t + 13, "s3a_resume", 2, 1, 0, 0, 8'h20);
        expect_at(t + 17, "s3a_f3",     3, 1, 0, 0, 8'h20);
        expect_at(t + 25, "s3a_at5",    5, 0, 0, 1, 8'h00);
        drive(t, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 1);
        drive(t + 3, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1);
        wait_drain("s3a");

        // Down hall call at 2: passed going up, served after reversing at 5.
        run_reset();
        t = cyc;
        expect_at(t + 6,  "s3b_f1",     1, 1, 0, 0, 8'h24);
        expect_at(t + 10, "s3b_pass2",  2, 1, 0, 0, 8'h24);
        expect_at(t + 22, "s3b_at5",    5, 0, 0, 1, 8'h04);
        expect_at(t + 25, "s3b_rev",    5, 0, 1, 0, 8'h04);
        expect_at(t + 29, "s3b_f4",     4, 0, 1, 0, 8'h04);
        expect_at(t + 37, "s3b_stop2",  2, 0, 0, 1, 8'h00);
        expect_at(t + 40, "s3b_idle",   2, 0, 0, 0, 8'h00);
        drive(t, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 1);
        drive(t + 3, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1);
        wait_drain("s3b");

        // Cab call for the open-door floor on the last door cycle extends the dwell.
        run_reset();
        t = cyc;
        expect_at(t + 18, "s4_door",    4, 0, 0, 1, 8'h00);
        expect_at(t + 20, "s4_last",    4, 0, 0, 1, 8'h00);
        expect_at(t + 21, "s4_extend",  4, 0, 0, 1, 8'h00);
        expect_at(t + 23, "s4_ext_end", 4, 0, 0, 1, 8'h00);
        expect_at(t + 24, "s4_idle",    4, 0, 0, 0, 8'h00);
        drive(t, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 1);
        drive(t + 20, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 1);
        wait_drain("s4");

        // LOOK order: at 4 going up with cabs 6 and 1 -> serve 6, then 1.
        run_reset();
        t = cyc;
        expect_at(t + 20, "s6_both",   4, 0, 0, 1, 8'h42);
        expect_at(t + 21, "s6_up",     4, 1, 0, 0, 8'h42);
        expect_at(t + 29, "s6_at6",    6, 0, 0, 1, 8'h02);
        expect_at(t + 32, "s6_down",   6, 0, 1, 0, 8'h02);
        expect_at(t + 36, "s6_f5",     5, 0, 1, 0, 8'h02);
        expect_at(t + 52, "s6_at1",    1, 0, 0, 1, 8'h00);
        expect_at(t + 55, "s6_idle",   1, 0, 0, 0, 8'h00);
        drive(t, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 1);
        drive(t + 18, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1, 1);
        drive(t + 19, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 1);
        wait_drain("s6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
